// File: rtl/memory_stage_pkg.sv
// Shared CPU definitions used by the memory stage: data/register widths and
// the request FSM state encoding.
package memory_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMEM_WAIT = 2'd1,
        BUS_WAIT  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/memory_stage_req_fsm.sv
// Request/timeout FSM for one memory-like port: holds the request until
// ack/valid arrives, or aborts after ACK_TIMEOUT wait cycles.
module mem_req_fsm
    import memory_stage_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 64,
    parameter mem_state_e WAIT_ST     = DMEM_WAIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_op,
    input  logic       i_ack,
    output logic       o_req,
    output logic       o_stall,
    output logic       o_timeout,
    output logic [1:0] o_state
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

    mem_state_e  r_state;
    mem_state_e  w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_cnt_inc;
    logic        w_req;
    logic        w_stall;
    logic        w_timeout;

    assign w_cnt_inc = r_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        if (r_state == IDLE) begin
            if (i_op) begin
                w_req = 1'b1;
                if (!i_ack) begin
                    w_stall     = 1'b1;
                    w_state_nxt = WAIT_ST;
                    w_cnt_nxt   = 16'd0;
                end
            end
        end else begin
            w_cnt_nxt = w_cnt_inc;
            if (!i_op) begin
                w_state_nxt = IDLE;
            end else if (i_ack) begin
                // ack wins over a coincident timeout
                w_req       = 1'b1;
                w_state_nxt = IDLE;
            end else if (w_cnt_inc == TIMEOUT_CNT) begin
                w_timeout   = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                w_req   = 1'b1;
                w_stall = 1'b1;
            end
        end
    end

    // Reset drops the request combinationally, even mid-operation.
    assign o_req     = w_req & rst_n;
    assign o_stall   = w_stall & rst_n;
    assign o_timeout = w_timeout & rst_n;
    assign o_state   = r_state;

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues data-memory or NN-bus accesses, stalls the
// upstream pipe while waiting, and produces current and one-cycle-older results.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_bustoreg,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_alu_src2_out,
    input  logic [3:0]  ex_regwraddr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        bus_rd_req,
    output logic [15:0] bus_addr,
    input  logic        bus_rd_valid,
    input  logic [15:0] bus_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        mem_regwrite,
    output logic [3:0]  mem_regwraddr,
    output logic [15:0] mem_regwrdata,
    output logic        mem_regwrite_prev,
    output logic [3:0]  mem_regwraddr_prev,
    output logic [15:0] mem_regwrdata_prev,
    output logic [1:0]  dbg_state
);

    logic                  w_mem_op;
    logic                  w_bus_op;
    logic                  w_dmem_stall;
    logic                  w_bus_stall;
    logic                  w_dmem_timeout;
    logic                  w_bus_timeout;
    logic [1:0]            w_dmem_state;
    logic [1:0]            w_bus_state;
    logic                  w_stall;
    logic                  w_timeout;
    logic [DATA_W-1:0]     w_wrdata;

    logic                  r_regwrite;
    logic [REG_ADDR_W-1:0] r_regwraddr;
    logic [DATA_W-1:0]     r_regwrdata;
    logic                  r_regwrite_prev;
    logic [REG_ADDR_W-1:0] r_regwraddr_prev;
    logic [DATA_W-1:0]     r_regwrdata_prev;
    logic                  r_err;

    // Stores and loads share the dmem port; a bus read only runs when neither is set.
    assign w_mem_op = ex_memwrite | ex_memread;
    assign w_bus_op = ex_bustoreg & ~w_mem_op;

    mem_req_fsm #(.ACK_TIMEOUT(ACK_TIMEOUT), .WAIT_ST(DMEM_WAIT)) u_dmem_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_op      (w_mem_op),
        .i_ack     (dmem_ack),
        .o_req     (dmem_req),
        .o_stall   (w_dmem_stall),
        .o_timeout (w_dmem_timeout),
        .o_state   (w_dmem_state)
    );

    mem_req_fsm #(.ACK_TIMEOUT(ACK_TIMEOUT), .WAIT_ST(BUS_WAIT)) u_bus_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_op      (w_bus_op),
        .i_ack     (bus_rd_valid),
        .o_req     (bus_rd_req),
        .o_stall   (w_bus_stall),
        .o_timeout (w_bus_timeout),
        .o_state   (w_bus_state)
    );

    assign dmem_we    = ex_memwrite;
    assign dmem_addr  = ex_alu_out;
    assign dmem_wdata = ex_alu_src2_out;
    assign bus_addr   = ex_alu_out;

    assign w_stall   = w_dmem_stall | w_bus_stall;
    assign w_timeout = w_dmem_timeout | w_bus_timeout;

    always_comb begin
        w_wrdata = ex_alu_out;
        if (w_timeout) begin
            w_wrdata = '0;
        end else if (ex_memtoreg) begin
            w_wrdata = dmem_rdata;
        end else if (ex_bustoreg) begin
            w_wrdata = bus_rdata;
        end
    end

    // Any non-stall cycle is a completion (ALU, acked access or timeout).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite       <= 1'b0;
            r_regwraddr      <= '0;
            r_regwrdata      <= '0;
            r_regwrite_prev  <= 1'b0;
            r_regwraddr_prev <= '0;
            r_regwrdata_prev <= '0;
            r_err            <= 1'b0;
        end else begin
            r_regwrite_prev  <= r_regwrite;
            r_regwraddr_prev <= r_regwraddr;
            r_regwrdata_prev <= r_regwrdata;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_stall) begin
                r_regwrite <= 1'b0;
            end else begin
                r_regwrite  <= ex_regwrite;
                r_regwraddr <= ex_regwraddr;
                r_regwrdata <= w_wrdata;
            end
        end
    end

    assign mem_stall          = w_stall;
    assign mem_err            = r_err;
    assign mem_regwrite       = r_regwrite;
    assign mem_regwraddr      = r_regwraddr;
    assign mem_regwrdata      = r_regwrdata;
    assign mem_regwrite_prev  = r_regwrite_prev;
    assign mem_regwraddr_prev = r_regwraddr_prev;
    assign mem_regwrdata_prev = r_regwrdata_prev;
    assign dbg_state          = (w_dmem_state != 2'd0) ? w_dmem_state : w_bus_state;

endmodule
